avalon_pair_writer: RTL
=======================

Name: avalon_pair_writer

Overview:
- Upstream feeder for the Avalon-MM operand-register slave that computes R = A*8 - B.
- Accepts operand pairs {A,B} on an Avalon-ST sink and buffers them in a small FIFO.
- Drains each pair as two Avalon-MM master writes: A to address 0x00, then B to address 0x01, honouring waitrequest.

Parameters:
- N, 32, operand width; equals the target's writedata width.
- DEPTH, 4, FIFO depth in pairs; power of 2, minimum 2.

Ports:
- csi_clk  input  1  clock
- rsi_reset_n  input  1  reset; one clock; asynchronous, active-low
- asi_in_data  input  2*N  pair; [2N-1:N] = A, [N-1:0] = B
- asi_in_valid  input  1  sink valid
- asi_in_ready  output  1  sink ready; equals !full
- avm_m0_address  output  8  master address
- avm_m0_write  output  1  master write strobe
- avm_m0_writedata  output  N  master write data
- avm_m0_waitrequest  input  1  slave stall
- coe_busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE
- coe_pair_cnt  output  16  completed-pair count; present only with PAIR_CNT_EN

Behaviour:
- Reset (asynchronous, rsi_reset_n=0):
  - FIFO emptied, FSM to IDLE.
  - avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0.
  - asi_in_ready=1 once reset is released; coe_busy=0; coe_pair_cnt=0.
- Sink:
  - A beat is accepted on a clock edge with asi_in_valid && asi_in_ready.
  - When full, asi_in_ready=0 even if a pop occurs in the same cycle; no bypass.
- FIFO:
  - Registered storage; count/pointers update at the edge.
  - Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- FSM, all master outputs registered:
  - IDLE: if the FIFO is non-empty, load head A into writedata, address=0x00, write=1; go to WR_A.
  - WR_A: hold outputs while waitrequest=1. On an edge with waitrequest=0: writedata=B of head, address=0x01, write stays 1; go to WR_B.
  - WR_B: hold outputs while waitrequest=1. On an edge with waitrequest=0: pop the FIFO head.
    - If another pair remains after the pop, load its A, address=0x00; go to WR_A (back-to-back, no idle cycle).
    - Otherwise write=0; go to IDLE.
- Write strobe:
  - avm_m0_write never deasserts mid-pair.
  - address/writedata are stable whenever write=1 and waitrequest=1.
- Latency, empty FIFO and waitrequest=0: beat accepted at edge E0; write A visible after E1; write B visible after E2; the pop happens at E3.
- Pair ordering is strict FIFO. A always precedes B, and the slave never sees B of pair k+1 before A of pair k+1.
- waitrequest held high indefinitely: outputs are frozen; the FIFO keeps accepting until full.
- Reset mid-pair: the transaction aborts immediately. The slave may hold a new A with a stale B; this is accepted behaviour, and software re-sends after reset.
- Data is passed through unmodified; no arithmetic or width change.

Optional Feature:
- Macro: AVALON_PAIR_WRITER_PAIR_CNT_EN
- Defined:
  - coe_pair_cnt exists and increments by 1 on each WR_B completion edge.
  - It wraps 0xFFFF -> 0x0000 and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package avalon_pair_writer_pkg:
  - typedef enum logic [1:0] {IDLE, WR_A, WR_B} wr_state_t
  - localparam ADDR_A = 8'h00, ADDR_B = 8'h01
- Sub-module pair_fifo (parameters W = 2*N, DEPTH):
  - Ports: push, pop, din, dout (head, combinational from storage), full, empty.
  - Same clock and asynchronous active-low reset as the top.

Test Plan:
- Reset then single pair A=5, B=3, waitrequest=0 -> write (0x00, 5) then (0x01, 3) on consecutive cycles; write=1 for exactly 2 cycles; coe_busy returns to 0.
- Three pairs (1,2), (3,4), (5,6) pushed back-to-back -> six consecutive write cycles with addresses 0,1,0,1,0,1 and data 1,2,3,4,5,6; no gap cycles.
- waitrequest=1 for 3 cycles during WR_A of pair (7,9) -> address 0x00, data 7 held 4 cycles, then (0x01, 9) for 1 cycle.
- waitrequest held high and DEPTH+2 valid beats offered -> asi_in_ready=0 after DEPTH accepts. After release, exactly DEPTH+2 pairs are delivered in order with none lost or duplicated.
- rsi_reset_n pulsed low during WR_B -> write=0 asynchronously, asi_in_ready=1, coe_busy=0 after release; the next pair (0xA, 0xB) is delivered correctly.
- With AVALON_PAIR_WRITER_PAIR_CNT_EN, 3 pairs sent -> coe_pair_cnt=3; preloaded near 0xFFFF, it wraps to 0.

Source files
------------

// File: rtl/avalon_pair_writer_pkg.sv
// Shared types and constants for avalon_pair_writer.
//   wr_state_t : master write sequencer states
//   ADDR_A     : target register address that receives operand A
//   ADDR_B     : target register address that receives operand B
package avalon_pair_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } wr_state_t;

  localparam logic [7:0] ADDR_A = 8'h00;
  localparam logic [7:0] ADDR_B = 8'h01;

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO holding operand pairs for avalon_pair_writer.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, din_i  : write an entry (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   dout_o         : head entry, read combinationally from storage
//   dout_next_o    : top NEXT_W bits of the entry behind the head
//   multi_o        : more than one entry is stored
//   full_o, empty_o: occupancy flags
// DEPTH must be a power of two (pointers wrap by natural overflow), minimum 2.
module pair_fifo #(
  parameter int W      = 64,
  parameter int DEPTH  = 4,
  parameter int NEXT_W = W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [W-1:0]      din_i,
  output logic [W-1:0]      dout_o,
  output logic [NEXT_W-1:0] dout_next_o,
  output logic              multi_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_next;
  logic          do_push, do_pop;
  logic [W-1:0]  next_entry;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign multi_o = (count_q > (AW+1)'(1));

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign rd_next     = rd_ptr_q + AW'(1);
  assign dout_o      = mem_q[rd_ptr_q];
  assign next_entry  = mem_q[rd_next];
  assign dout_next_o = next_entry[W-1 -: NEXT_W];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_next;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: an entry is only ever read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/avalon_pair_writer.sv
// Feeds operand pairs {A,B} from an Avalon-ST sink into an Avalon-MM slave
// as two writes per pair: A to ADDR_A, then B to ADDR_B.
// Ports:
//   csi_clk, rsi_reset_n : clock, asynchronous active-low reset
//   asi_in_*             : Avalon-ST sink; data[2N-1:N]=A, data[N-1:0]=B
//   avm_m0_*             : Avalon-MM master (address, write, writedata, waitrequest)
//   coe_busy             : FIFO non-empty or a pair write in progress
//   coe_pair_cnt         : completed-pair count (only with AVALON_PAIR_WRITER_PAIR_CNT_EN)
// Handshakes: a sink beat transfers on an edge where asi_in_valid && asi_in_ready;
// a master write transfers on an edge where avm_m0_write && !avm_m0_waitrequest.
// Address/writedata/write are held unchanged while waitrequest is high.
// Optional feature macro: AVALON_PAIR_WRITER_PAIR_CNT_EN.
module avalon_pair_writer
  import avalon_pair_writer_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         csi_clk,
  input  logic         rsi_reset_n,
  input  logic [2*N-1:0] asi_in_data,
  input  logic         asi_in_valid,
  output logic         asi_in_ready,
  output logic [7:0]   avm_m0_address,
  output logic         avm_m0_write,
  output logic [N-1:0] avm_m0_writedata,
  input  logic         avm_m0_waitrequest,
  output logic         coe_busy
`ifdef AVALON_PAIR_WRITER_PAIR_CNT_EN
  ,
  output logic [15:0]  coe_pair_cnt
`endif
);

  wr_state_t      state_q, state_d;
  logic [7:0]     addr_q, addr_d;
  logic [N-1:0]   wdata_q, wdata_d;
  logic           write_q, write_d;

  logic           fifo_push, fifo_pop;
  logic           fifo_full, fifo_empty, fifo_multi;
  logic [2*N-1:0] fifo_head;
  logic [N-1:0]   fifo_next_a;
  logic           pair_done;

  // No bypass: a full FIFO refuses the beat even if the head pops this cycle.
  assign asi_in_ready = !fifo_full;
  assign fifo_push    = asi_in_valid && !fifo_full;

  pair_fifo #(
    .W      (2*N),
    .DEPTH  (DEPTH),
    .NEXT_W (N)
  ) u_fifo (
    .clk_i       (csi_clk),
    .rst_ni      (rsi_reset_n),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .din_i       (asi_in_data),
    .dout_o      (fifo_head),
    .dout_next_o (fifo_next_a),
    .multi_o     (fifo_multi),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // The pair under transfer stays at the FIFO head until its B write completes,
  // so busy reduces to "FIFO non-empty or sequencer active".
  assign pair_done = (state_q == WR_B) && !avm_m0_waitrequest;
  assign coe_busy  = !fifo_empty || (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          wdata_d = fifo_head[2*N-1:N];
          addr_d  = ADDR_A;
          write_d = 1'b1;
          state_d = WR_A;
        end
      end
      WR_A: begin
        if (!avm_m0_waitrequest) begin
          wdata_d = fifo_head[N-1:0];
          addr_d  = ADDR_B;
          state_d = WR_B;
        end
      end
      WR_B: begin
        if (!avm_m0_waitrequest) begin
          fifo_pop = 1'b1;
          // Only a pair already stored can follow back-to-back; one pushed on
          // this same edge is picked up from IDLE next cycle.
          if (fifo_multi) begin
            wdata_d = fifo_next_a;
            addr_d  = ADDR_A;
            state_d = WR_A;
          end else begin
            write_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign avm_m0_address   = addr_q;
  assign avm_m0_write     = write_q;
  assign avm_m0_writedata = wdata_q;

`ifdef AVALON_PAIR_WRITER_PAIR_CNT_EN
  logic [15:0] pair_cnt_q, pair_cnt_d;

  // Wraps 0xFFFF -> 0x0000 by natural overflow.
  assign pair_cnt_d = pair_done ? pair_cnt_q + 16'd1 : pair_cnt_q;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) pair_cnt_q <= '0;
    else              pair_cnt_q <= pair_cnt_d;
  end

  assign coe_pair_cnt = pair_cnt_q;
`else
  logic unused_pair_done;
  assign unused_pair_done = pair_done;
`endif

endmodule
